// File: rtl/fb_pkg.sv
// Shared types and sizing helpers for the frame buffer controller.
package fb_pkg;

  // Write side: wait for a full line in the input FIFO, then burst it.
  typedef enum logic {
    W_IDLE  = 1'b0,
    W_BURST = 1'b1
  } wr_state_t;

  // Read side: idle until a display request, then stream one frame.
  typedef enum logic {
    R_IDLE   = 1'b0,
    R_ACTIVE = 1'b1
  } rd_state_t;

  // Bank indices are always carried in two bits, even for a single bank.
  localparam int BANK_W = 2;

  function automatic int num_banks(input int triple_buf);
    return (triple_buf != 0) ? 3 : 1;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int addr_w(input int depth);
    return cnt_w(depth);
  endfunction

  // Lowest bank index that differs from both a and b. When a and b differ
  // in a three-bank system this is the single remaining bank.
  function automatic logic [BANK_W-1:0] free_bank(input logic [BANK_W-1:0] a,
                                                  input logic [BANK_W-1:0] b,
                                                  input int nbanks);
    logic [BANK_W-1:0] res;
    res = '0;
    if (nbanks > 1) begin
      for (int i = 2; i >= 0; i--) begin
        if ((BANK_W'(i) != a) && (BANK_W'(i) != b)) res = BANK_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fb_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a fixed
// RD_LATENCY-cycle registered read path.
module fb_sdp_ram
  import fb_pkg::*;
#(
  parameter int DEPTH      = 96,
  parameter int DATA_WIDTH = 12,
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = addr_w(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_clr,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] r_stage [RD_LATENCY];

  // Write port.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port: first stage captures the array on a read, the remaining
  // stages shift every cycle so data timing matches a plain delay line.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < RD_LATENCY; i++) r_stage[i] <= '0;
    end else begin
      if (i_re) r_stage[0] <= r_mem[i_raddr];
      for (int i = 1; i < RD_LATENCY; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_rdata = r_stage[RD_LATENCY-1];

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Frame buffer between the camera input FIFO and the display output FIFO.
// Lines are burst into RAM banks; frames are streamed out on request.
// With three banks the writer always avoids the bank being displayed.
//
// Handshakes: o_rd consumes i_rdata in the same cycle (FWFT input FIFO);
// o_wr pushes o_wdata in the same cycle; i_almostfull stalls the next read
// issue, so up to RD_LATENCY writes may still land after it rises.
module frame_buffer_ctrl
  import fb_pkg::*;
#(
  parameter int DATA_WIDTH  = 12,
  parameter int FILL_WIDTH  = 10,
  parameter int LINE_PIXELS = 640,
  parameter int FRAME_LINES = 480,
  parameter int TRIPLE_BUF  = 1,
  parameter int RD_LATENCY  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_flush,
  input  logic                  i_req,
  output logic                  o_rd,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [FILL_WIDTH-1:0] i_rfill,
  output logic                  o_wr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic                  i_almostfull,
  output logic [1:0]            o_wr_bank,
  output logic [1:0]            o_rd_bank,
  output logic                  o_frame_done,
  output logic                  o_drop,
  output logic                  o_rd_busy
);

  localparam int NUM_BANKS    = num_banks(TRIPLE_BUF);
  localparam int FRAME_PIXELS = LINE_PIXELS * FRAME_LINES;
  localparam int DEPTH        = NUM_BANKS * FRAME_PIXELS;
  localparam int ADDR_W       = addr_w(DEPTH);
  localparam int OFF_W        = cnt_w(FRAME_PIXELS);
  localparam int PIX_W        = cnt_w(LINE_PIXELS);
  localparam int LINE_W       = cnt_w(FRAME_LINES);

  localparam logic [PIX_W-1:0]      PIX_LAST  = PIX_W'(LINE_PIXELS - 1);
  localparam logic [LINE_W-1:0]     LINE_LAST = LINE_W'(FRAME_LINES - 1);
  localparam logic [OFF_W-1:0]      OFF_LAST  = OFF_W'(FRAME_PIXELS - 1);
  localparam logic [FILL_WIDTH-1:0] FILL_LINE = FILL_WIDTH'(LINE_PIXELS);

  // Bank base addresses are constants, so no multiplier is needed.
  function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] bank);
    logic [ADDR_W-1:0] res;
    case (bank)
      2'd1:    res = ADDR_W'(FRAME_PIXELS);
      2'd2:    res = ADDR_W'(FRAME_PIXELS + FRAME_PIXELS);
      default: res = '0;
    endcase
    return res;
  endfunction

  logic w_clr;
  assign w_clr = !i_rstn || i_flush;

  // ---------------------------------------------------------------- write
  wr_state_t          r_wstate;
  logic               r_rd;
  logic [PIX_W-1:0]   r_pix;
  logic [LINE_W-1:0]  r_line;
  logic [OFF_W-1:0]   r_wr_off;
  logic [ADDR_W-1:0]  r_wr_base;
  logic [1:0]         r_wr_bank;
  logic               w_frame_end;
  logic [ADDR_W-1:0]  w_waddr;

  assign w_frame_end = r_rd && (r_pix == PIX_LAST) && (r_line == LINE_LAST);
  assign w_waddr     = r_wr_base + ADDR_W'(r_wr_off);

  // Write FSM: one line per burst, always returning to idle for a cycle.
  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_wstate <= W_IDLE;
      r_rd     <= 1'b0;
      r_pix    <= '0;
      r_line   <= '0;
      r_wr_off <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (i_rfill >= FILL_LINE) begin
            r_wstate <= W_BURST;
            r_rd     <= 1'b1;
          end
        end
        W_BURST: begin
          if (r_pix == PIX_LAST) begin
            r_wstate <= W_IDLE;
            r_rd     <= 1'b0;
            r_pix    <= '0;
            if (r_line == LINE_LAST) begin
              r_line   <= '0;
              r_wr_off <= '0;
            end else begin
              r_line   <= r_line + 1'b1;
              r_wr_off <= r_wr_off + 1'b1;
            end
          end else begin
            r_pix    <= r_pix + 1'b1;
            r_wr_off <= r_wr_off + 1'b1;
          end
        end
        default: begin
          r_wstate <= W_IDLE;
          r_rd     <= 1'b0;
        end
      endcase
    end
  end

  // ----------------------------------------------------- request sync
  logic r_req_s1;
  logic r_req_s2;
  logic r_req_d;
  logic w_req_edge;

  // Two-flop synchroniser plus one flop for rising-edge detection.
  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_req_s1 <= 1'b0;
      r_req_s2 <= 1'b0;
      r_req_d  <= 1'b0;
    end else begin
      r_req_s1 <= i_req;
      r_req_s2 <= r_req_s1;
      r_req_d  <= r_req_s2;
    end
  end

  assign w_req_edge = r_req_s2 && !r_req_d;

  // ----------------------------------------------------------------- read
  rd_state_t          r_rstate;
  logic               r_busy;
  logic [OFF_W-1:0]   r_rd_off;
  logic [ADDR_W-1:0]  r_rd_base;
  logic [1:0]         r_rd_bank;
  logic               w_rd_start;
  logic               w_issue;
  logic [ADDR_W-1:0]  w_raddr;

  // Requests arriving mid-frame are ignored.
  assign w_rd_start = (r_rstate == R_IDLE) && w_req_edge;
  assign w_issue    = (r_rstate == R_ACTIVE) && !i_almostfull;
  assign w_raddr    = r_rd_base + ADDR_W'(r_rd_off);

  // Read FSM: one RAM read per non-stalled cycle until the frame is out.
  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_rstate <= R_IDLE;
      r_busy   <= 1'b0;
      r_rd_off <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_req_edge) begin
            r_rstate <= R_ACTIVE;
            r_busy   <= 1'b1;
            r_rd_off <= '0;
          end
        end
        R_ACTIVE: begin
          if (!i_almostfull) begin
            if (r_rd_off == OFF_LAST) begin
              r_rstate <= R_IDLE;
              r_busy   <= 1'b0;
              r_rd_off <= '0;
            end else begin
              r_rd_off <= r_rd_off + 1'b1;
            end
          end
        end
        default: begin
          r_rstate <= R_IDLE;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------ bank handover
  logic [1:0] r_ready_bank;
  logic       r_ready_valid;
  logic       r_frame_done;
  logic       r_drop;
  logic [1:0] w_rd_bank_nxt;
  logic [1:0] w_wr_bank_nxt;

  // A starting read takes the registered ready bank, or repeats its own
  // bank when nothing new is ready. The writer's next bank avoids the bank
  // the reader holds after this cycle, so a read starting together with a
  // frame completion is still protected.
  assign w_rd_bank_nxt = (w_rd_start && r_ready_valid) ? r_ready_bank : r_rd_bank;
  assign w_wr_bank_nxt = free_bank(r_wr_bank, w_rd_bank_nxt, NUM_BANKS);

  // Bank bookkeeping shared by both sides, plus the status pulses.
  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_wr_bank     <= '0;
      r_wr_base     <= '0;
      r_rd_bank     <= '0;
      r_rd_base     <= '0;
      r_ready_bank  <= '0;
      r_ready_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      r_drop       <= w_frame_end && r_ready_valid && !w_rd_start;
      if (w_rd_start) begin
        r_rd_bank <= w_rd_bank_nxt;
        r_rd_base <= base_of(w_rd_bank_nxt);
      end
      if (w_frame_end) begin
        r_ready_bank  <= r_wr_bank;
        r_ready_valid <= 1'b1;
        r_wr_bank     <= w_wr_bank_nxt;
        r_wr_base     <= base_of(w_wr_bank_nxt);
      end else if (w_rd_start) begin
        r_ready_valid <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------- read pipeline
  logic [RD_LATENCY-1:0] r_issue_pipe;

  // Read strobe delayed to line up with the RAM output data.
  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_issue_pipe <= '0;
    end else begin
      r_issue_pipe[0] <= w_issue;
      for (int i = 1; i < RD_LATENCY; i++) r_issue_pipe[i] <= r_issue_pipe[i-1];
    end
  end

  fb_sdp_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_clr   (w_clr),
    .i_we    (r_rd),
    .i_waddr (w_waddr),
    .i_wdata (i_rdata),
    .i_re    (w_issue),
    .i_raddr (w_raddr),
    .o_rdata (o_wdata)
  );

  assign o_rd         = r_rd;
  assign o_wr         = r_issue_pipe[RD_LATENCY-1];
  assign o_wr_bank    = r_wr_bank;
  assign o_rd_bank    = r_rd_bank;
  assign o_frame_done = r_frame_done;
  assign o_drop       = r_drop;
  assign o_rd_busy    = r_busy;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl with 8x4 frames and read latency 2.
module tb_frame_buffer_ctrl;

  localparam int DW  = 12;
  localparam int FW  = 10;
  localparam int FP  = 32;

  // ---------------------------------------------------- clock / reset
  logic          clk;
  logic          i_rstn;
  logic          i_flush;
  logic          i_req;
  logic          o_rd;
  logic [DW-1:0] i_rdata;
  logic [FW-1:0] i_rfill;
  logic          o_wr;
  logic [DW-1:0] o_wdata;
  logic          i_almostfull;
  logic [1:0]    o_wr_bank;
  logic [1:0]    o_rd_bank;
  logic          o_frame_done;
  logic          o_drop;
  logic          o_rd_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  frame_buffer_ctrl #(
    .DATA_WIDTH  (DW),
    .FILL_WIDTH  (FW),
    .LINE_PIXELS (8),
    .FRAME_LINES (4),
    .TRIPLE_BUF  (1),
    .RD_LATENCY  (2)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (i_rstn),
    .i_flush      (i_flush),
    .i_req        (i_req),
    .o_rd         (o_rd),
    .i_rdata      (i_rdata),
    .i_rfill      (i_rfill),
    .o_wr         (o_wr),
    .o_wdata      (o_wdata),
    .i_almostfull (i_almostfull),
    .o_wr_bank    (o_wr_bank),
    .o_rd_bank    (o_rd_bank),
    .o_frame_done (o_frame_done),
    .o_drop       (o_drop),
    .o_rd_busy    (o_rd_busy)
  );

  // ------------------------------------------------------- scoreboard
  logic [DW-1:0] exp_q[$];
  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int af_mode  = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int drop_cnt = 0;
  int tear_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------- driver
  // One clock: the input FIFO pops on every cycle o_rd was high, outputs
  // are sampled 1 ns after the edge and output writes go to the scoreboard.
  task automatic step();
    logic consumed;
    consumed = o_rd;
    @(posedge clk);
    #1;
    cyc++;
    if (consumed) begin
      i_rdata = i_rdata + 1'b1;
      i_rfill = i_rfill - 1'b1;
    end
    case (af_mode)
      1:       i_almostfull = ((cyc / 3) % 2) == 1;
      2:       i_almostfull = (cyc % 4) != 0;
      default: i_almostfull = 1'b0;
    endcase
    if (o_rd) rd_cnt++;
    if (o_frame_done) done_cnt++;
    if (o_drop) drop_cnt++;
    if (o_rd && o_rd_busy && (o_wr_bank == o_rd_bank)) tear_cnt++;
    if (o_wr) begin
      wr_cnt++;
      check("wr_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("wr_data", o_wdata, exp_q.pop_front());
    end
  endtask

  task automatic wait_frames(input int n, input string tag);
    int k;
    k = 0;
    while (done_cnt < n && k < 400) begin
      step();
      k++;
    end
    check({tag, "_frame_timeout"}, done_cnt >= n, 1'b1);
  endtask

  task automatic wait_read(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || o_rd_busy) && k < 800) begin
      step();
      k++;
    end
    repeat (4) step();
    check({tag, "_timeout"}, k < 800, 1'b1);
    check({tag, "_left"}, exp_q.size(), 0);
  endtask

  task automatic do_read(input int base, input logic [1:0] bank, input string tag);
    for (int i = 0; i < FP; i++) exp_q.push_back(DW'(base + i));
    wr_cnt = 0;
    i_req  = 1'b1;
    repeat (4) step();
    i_req  = 1'b0;
    check({tag, "_bank"}, o_rd_bank, bank);
    wait_read(tag);
    check({tag, "_count"}, wr_cnt, FP);
  endtask

  // ---------------------------------------------------- directed steps
  initial begin
    int first_wr;
    int k;
    int drop_at;
    logic [1:0] bank_a;
    i_rstn       = 1'b0;
    i_flush      = 1'b0;
    i_req        = 1'b0;
    i_rdata      = '0;
    i_rfill      = '0;
    i_almostfull = 1'b0;
    repeat (2) step();

    // Reset state.
    check("rst_o_rd", o_rd, 0);
    check("rst_o_wr", o_wr, 0);
    check("rst_o_wdata", o_wdata, 0);
    check("rst_wr_bank", o_wr_bank, 0);
    check("rst_rd_bank", o_rd_bank, 0);
    check("rst_frame_done", o_frame_done, 0);
    check("rst_drop", o_drop, 0);
    check("rst_busy", o_rd_busy, 0);
    i_rstn = 1'b1;

    // Seven pixels are not a line.
    i_rfill = 10'd7;
    rd_cnt  = 0;
    repeat (6) step();
    check("fill7_no_rd", rd_cnt, 0);

    // Nine pixels give exactly one line burst.
    i_rfill = 10'd9;
    repeat (15) step();
    check("fill9_rd_cycles", rd_cnt, 8);
    check("fill9_fill_left", i_rfill, 1);

    // Reset in the middle of a burst.
    i_rfill = 10'd9;
    repeat (3) step();
    check("burst_running", o_rd, 1);
    i_rstn = 1'b0;
    step();
    check("midrst_o_rd", o_rd, 0);
    check("midrst_o_wr", o_wr, 0);
    check("midrst_wr_bank", o_wr_bank, 0);
    check("midrst_busy", o_rd_busy, 0);
    i_rstn  = 1'b1;
    i_rdata = '0;
    i_rfill = '0;
    step();

    // Whole frame 0..31 into bank 0.
    rd_cnt   = 0;
    done_cnt = 0;
    drop_cnt = 0;
    i_rfill  = 10'd32;
    wait_frames(1, "frame0");
    check("frame0_rd_cycles", rd_cnt, 32);
    check("frame0_wr_bank", o_wr_bank, 1);
    check("frame0_no_drop", drop_cnt, 0);

    // First read: exact request-to-write latency, then full frame.
    for (int i = 0; i < FP; i++) exp_q.push_back(DW'(i));
    wr_cnt   = 0;
    first_wr = 0;
    i_req    = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      step();
      if (j == 2) check("busy_before_fsm", o_rd_busy, 0);
      if (j == 3) check("busy_after_fsm", o_rd_busy, 1);
      if (o_wr && first_wr == 0) first_wr = j;
    end
    i_req = 1'b0;
    check("rd_latency", first_wr, 5);
    check("read0_bank", o_rd_bank, 0);
    wait_read("read0");
    check("read0_count", wr_cnt, FP);

    // Backpressure on a repeat read of bank 0.
    af_mode = 1;
    do_read(0, 2'd0, "bp_read");
    af_mode = 0;

    // Two frames written while bank 0 is read slowly.
    for (int i = 0; i < FP; i++) exp_q.push_back(DW'(i));
    af_mode  = 2;
    wr_cnt   = 0;
    done_cnt = 0;
    drop_cnt = 0;
    tear_cnt = 0;
    drop_at  = 0;
    bank_a   = 2'd3;
    i_rdata  = 12'd100;
    i_rfill  = 10'd64;
    i_req    = 1'b1;
    k = 0;
    while ((done_cnt < 2 || exp_q.size() != 0 || o_rd_busy) && k < 1000) begin
      step();
      k++;
      if (k == 4) i_req = 1'b0;
      if (o_frame_done && done_cnt == 1) bank_a = o_wr_bank;
      if (o_drop) drop_at = done_cnt;
    end
    af_mode = 0;
    repeat (4) step();
    check("tb_timeout", k < 1000, 1'b1);
    check("tb_read_left", exp_q.size(), 0);
    check("tb_read_count", wr_cnt, FP);
    check("tb_frames", done_cnt, 2);
    check("tb_bank_after_a", bank_a, 2);
    check("tb_wr_bank_after_b", o_wr_bank, 1);
    check("tb_drop_count", drop_cnt, 1);
    check("tb_drop_on_second", drop_at, 2);
    check("tb_rd_bank_held", o_rd_bank, 0);
    check("tb_no_tear", tear_cnt, 0);

    // Newest frame lives in bank 2; a second request repeats it.
    do_read(132, 2'd2, "bank2_read");
    do_read(132, 2'd2, "repeat_read");
    check("repeat_wr_bank", o_wr_bank, 1);

    // Flush in the middle of a burst, then a fresh frame lands in bank 0.
    i_rfill = 10'd9;
    repeat (3) step();
    i_flush = 1'b1;
    step();
    check("flush_o_rd", o_rd, 0);
    check("flush_wr_bank", o_wr_bank, 0);
    check("flush_rd_bank", o_rd_bank, 0);
    check("flush_busy", o_rd_busy, 0);
    i_flush  = 1'b0;
    i_rdata  = 12'd500;
    i_rfill  = 10'd32;
    done_cnt = 0;
    drop_cnt = 0;
    wait_frames(1, "flush_frame");
    check("flush_frame_wr_bank", o_wr_bank, 1);
    check("flush_frame_no_drop", drop_cnt, 0);
    do_read(500, 2'd0, "flush_read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
